// File: rtl/twoportbram_clr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : twoportbram_clr                                              |
// | Description : Single-clock true dual-port RAM with per-lane write enables, |
// |               1- or 2-cycle read latency with valid tracking, defined      |
// |               same-address collision rules and a post-reset clear          |
// |               sequencer. Optional per-lane even parity is enabled by       |
// |               defining the macro TWOPORTBRAM_PARITY_EN.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module twoportbram_clr #(
  parameter int                   DATA_BITS    = 16,
  parameter int                   ADDRESS_BITS = 10,
  parameter int                   LANE_BITS    = 8,
  parameter int                   READ_LATENCY = 1,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE  = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en1,
  input  logic [ADDRESS_BITS-1:0]           addr1,
  input  logic [DATA_BITS-1:0]              din1,
  input  logic [DATA_BITS/LANE_BITS-1:0]    we1,
  output logic [DATA_BITS-1:0]              dout1,
  output logic                              valid1,
  input  logic                              en2,
  input  logic [ADDRESS_BITS-1:0]           addr2,
  input  logic [DATA_BITS-1:0]              din2,
  input  logic [DATA_BITS/LANE_BITS-1:0]    we2,
  output logic [DATA_BITS-1:0]              dout2,
  output logic                              valid2,
  output logic                              busy,
  output logic                              collision,
  output logic                              perr1,
  output logic                              perr2
);

  localparam int LANES = DATA_BITS / LANE_BITS;
  localparam int WORDS = 1 << ADDRESS_BITS;

  generate
    if (DATA_BITS % LANE_BITS != 0) begin : g_err_lanes
      $error("twoportbram_clr: DATA_BITS must be a multiple of LANE_BITS");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_latency
      $error("twoportbram_clr: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDRESS_BITS-1:0] clr_addr, clr_addr_nxt;
  logic                    clr_we;

  logic [DATA_BITS-1:0]    mem [WORDS];

  logic                    acc1, acc2, wr1, wr2;
  logic [DATA_BITS-1:0]    fin1, fin2;   // final stored word at each port's address
  logic [DATA_BITS-1:0]    rd1, rd2;     // word each port returns this cycle
  logic [LANES-1:0]        mm1, mm2;     // per-lane parity mismatch of rd1/rd2

  // Clear sequencer state register; reset restarts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Clear sequencer next state: one word per cycle, READY after the last word.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clr_we       = 1'b0;
    case (state)
      CLEAR: begin
        clr_we       = ~reset;
        clr_addr_nxt = clr_addr + 1'b1;
        if (&clr_addr) state_nxt = READY;
      end
      READY: begin
        state_nxt = READY;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy = (state == CLEAR);

  assign acc1 = en1 & ~busy & ~reset;
  assign acc2 = en2 & ~busy & ~reset;
  assign wr1  = acc1 & (|we1);
  assign wr2  = acc2 & (|we2);

  // Resolve lane merges: port 2 lanes first so port 1 overrides overlapping lanes.
  always_comb begin
    fin1 = mem[addr1];
    fin2 = mem[addr2];
    for (int l = 0; l < LANES; l++) begin
      if (wr2 && we2[l]) begin
        fin2[l*LANE_BITS +: LANE_BITS] = din2[l*LANE_BITS +: LANE_BITS];
        if (addr1 == addr2) fin1[l*LANE_BITS +: LANE_BITS] = din2[l*LANE_BITS +: LANE_BITS];
      end
      if (wr1 && we1[l]) begin
        fin1[l*LANE_BITS +: LANE_BITS] = din1[l*LANE_BITS +: LANE_BITS];
        if (addr1 == addr2) fin2[l*LANE_BITS +: LANE_BITS] = din1[l*LANE_BITS +: LANE_BITS];
      end
    end
  end

  // A writer sees the final stored word; a pure reader sees the old contents.
  assign rd1 = wr1 ? fin1 : mem[addr1];
  assign rd2 = wr2 ? fin2 : mem[addr2];

  // Memory array: clear sweep or port writes (both ports agree on a shared address).
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else begin
      if (wr1) mem[addr1] <= fin1;
      if (wr2) mem[addr2] <= fin2;
    end
  end

`ifdef TWOPORTBRAM_PARITY_EN
  logic [LANES-1:0] par [WORDS];
  logic [LANES-1:0] pfin1, pfin2, prd1, prd2;

  function automatic logic [LANES-1:0] lane_par(input logic [DATA_BITS-1:0] w);
    logic [LANES-1:0] p;
    p = '0;
    for (int l = 0; l < LANES; l++) p[l] = ^w[l*LANE_BITS +: LANE_BITS];
    return p;
  endfunction

  // Parity follows the same lane merge; unwritten lanes keep their stored bit.
  always_comb begin
    pfin1 = par[addr1];
    pfin2 = par[addr2];
    for (int l = 0; l < LANES; l++) begin
      if (wr2 && we2[l]) begin
        pfin2[l] = ^din2[l*LANE_BITS +: LANE_BITS];
        if (addr1 == addr2) pfin1[l] = ^din2[l*LANE_BITS +: LANE_BITS];
      end
      if (wr1 && we1[l]) begin
        pfin1[l] = ^din1[l*LANE_BITS +: LANE_BITS];
        if (addr1 == addr2) pfin2[l] = ^din1[l*LANE_BITS +: LANE_BITS];
      end
    end
  end

  assign prd1 = wr1 ? pfin1 : par[addr1];
  assign prd2 = wr2 ? pfin2 : par[addr2];
  assign mm1  = lane_par(rd1) ^ prd1;
  assign mm2  = lane_par(rd2) ^ prd2;

  // Parity storage, written alongside the data array.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par[clr_addr] <= lane_par(CLEAR_VALUE);
    end else begin
      if (wr1) par[addr1] <= pfin1;
      if (wr2) par[addr2] <= pfin2;
    end
  end
`else
  assign mm1 = '0;
  assign mm2 = '0;
`endif

  logic                 v1_s1, v2_s1, pe1_s1, pe2_s1;
  logic [DATA_BITS-1:0] d1_s1, d2_s1;

  // First output stage: valid follows acceptance, data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_s1  <= 1'b0;
      v2_s1  <= 1'b0;
      pe1_s1 <= 1'b0;
      pe2_s1 <= 1'b0;
      d1_s1  <= '0;
      d2_s1  <= '0;
    end else begin
      v1_s1  <= acc1;
      v2_s1  <= acc2;
      pe1_s1 <= acc1 & (|mm1);
      pe2_s1 <= acc2 & (|mm2);
      if (acc1) d1_s1 <= rd1;
      if (acc2) d2_s1 <= rd2;
    end
  end

  // Collision pulse: both ports wrote at least one common lane of one address.
  always_ff @(posedge clk) begin
    if (reset) collision <= 1'b0;
    else       collision <= wr1 & wr2 & (addr1 == addr2) & (|(we1 & we2));
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                 v1_s2, v2_s2, pe1_s2, pe2_s2;
      logic [DATA_BITS-1:0] d1_s2, d2_s2;

      // Second output stage, same hold behaviour as the first.
      always_ff @(posedge clk) begin
        if (reset) begin
          v1_s2  <= 1'b0;
          v2_s2  <= 1'b0;
          pe1_s2 <= 1'b0;
          pe2_s2 <= 1'b0;
          d1_s2  <= '0;
          d2_s2  <= '0;
        end else begin
          v1_s2  <= v1_s1;
          v2_s2  <= v2_s1;
          pe1_s2 <= pe1_s1;
          pe2_s2 <= pe2_s1;
          if (v1_s1) d1_s2 <= d1_s1;
          if (v2_s1) d2_s2 <= d2_s1;
        end
      end

      assign valid1 = v1_s2;
      assign valid2 = v2_s2;
      assign dout1  = d1_s2;
      assign dout2  = d2_s2;
      assign perr1  = pe1_s2;
      assign perr2  = pe2_s2;
    end else begin : g_lat1
      assign valid1 = v1_s1;
      assign valid2 = v2_s1;
      assign dout1  = d1_s1;
      assign dout2  = d2_s1;
      assign perr1  = pe1_s1;
      assign perr2  = pe2_s1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/twoportbram_clr.md
Name: twoportbram_clr

Overview:
Single-clock true dual-port block RAM and parametrised successor to the two-port BRAM used for tile storage. Adds the following:
- per-lane (byte) write enables;
- selectable read latency with valid tracking;
- defined same-address collision rules;
- a hardware clear sequencer that initialises every word after reset.

It sits between the tile fetch logic (port 1) and the Avalon/CPU write path (port 2).

Parameters:
DATA_BITS, 16, word width; must be a multiple of LANE_BITS
ADDRESS_BITS, 10, address width; WORDS = 1 << ADDRESS_BITS
LANE_BITS, 8, width of one write-enable lane; LANES = DATA_BITS/LANE_BITS
READ_LATENCY, 1, cycles from en to dout; legal values 1 or 2
CLEAR_VALUE, 0, DATA_BITS-wide word written to every address by the clear sequencer

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
en1  in  1  port 1 access request (read, or write when any we1 bit is set)
addr1  in  ADDRESS_BITS  port 1 address
din1  in  DATA_BITS  port 1 write data
we1  in  LANES  port 1 lane write enables
dout1  out  DATA_BITS  port 1 read data
valid1  out  1  dout1 holds data for an accepted en1
en2, addr2, din2, we2, dout2, valid2  same as port 1, for port 2
busy  out  1  clear sequencer active; all accesses are ignored
collision  out  1  one-cycle pulse: both ports wrote overlapping lanes of one address
perr1, perr2  out  1  parity error on the word presented with valid1/valid2

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values while reset=1: dout1 and dout2 = 0, valid1 and valid2 = 0, collision = 0, perr1 and perr2 = 0, busy = 1, clear address = 0.
- Clear FSM has two states: CLEAR and READY.
  - CLEAR is entered on reset.
  - In CLEAR, one word per cycle is written with CLEAR_VALUE, for addresses 0 to WORDS-1.
  - After the last address is written, the FSM moves to READY and busy drops on the following cycle.
  - Clearing takes exactly WORDS cycles after reset deasserts.
  - If reset is reasserted mid-clear, the sequence restarts at address 0.
- While busy = 1:
  - en1 and en2 are ignored: no memory write, valid stays 0.
  - collision stays 0.
- Access acceptance: an access on port p is accepted when en_p = 1 and busy = 0. Any we_p bit set makes it a write; only the enabled lanes are updated.
- Latency:
  - READ_LATENCY = 1: valid_p and dout_p appear on the edge after acceptance.
  - READ_LATENCY = 2: one extra output register stage.
  - Both stages are flushed to 0 by reset.
- Output hold: when en_p = 0, valid_p drops at the matching latency and dout_p holds its last value.
- Same-port read-during-write is write-first. dout_p = the merged word: written lanes take din_p, unwritten lanes take the old contents.
- Cross-port read of an address the other port writes in the same cycle is read-first: the reader returns the old word.
- Both ports write the same address in one cycle:
  - port 1 wins each overlapping lane;
  - non-overlapping lanes from both ports are written;
  - collision pulses high for 1 cycle only if at least one lane overlaps.
  - Each writer's dout shows the final stored word.
- Addresses wrap naturally at ADDRESS_BITS; there is no out-of-range condition.
- Elaboration: DATA_BITS % LANE_BITS != 0, or READ_LATENCY not in {1,2}, is an elaboration error ($error).

Optional Feature:
Macro TWOPORTBRAM_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, computed from din on write and by the clear sequencer.
  - On read, parity is rechecked per lane.
  - perr_p = OR of lane mismatches, aligned with valid_p, and asserted only when valid_p = 1.
- Undefined: no parity storage; perr1 and perr2 are tied to 0.

Test Plan:
(All scenarios use DATA_BITS=16, LANE_BITS=8, ADDRESS_BITS=4, CLEAR_VALUE=16'hA5A5.)
- Clear: reset for 2 cycles, then release -> busy = 1 for exactly 16 cycles, then 0. Reads of addresses 0 to 15 return 16'hA5A5 with valid1 = 1, one cycle later (READ_LATENCY = 1).
- Byte enables and same-port read-during-write: port 1 writes addr 3, din1 = 16'h1234, we1 = 2'b01 -> dout1 = 16'hA534 next cycle. A later port 2 read of addr 3 -> 16'hA534.
- Collision:
  - Stimulus, same cycle: port 1 writes addr 5, 16'h1111, we 2'b11; port 2 writes addr 5, 16'h2222, we 2'b10.
  - Required: collision = 1 for 1 cycle; stored word = 16'h1111; both douts = 16'h1111.
  - With we1 = 2'b01 and we2 = 2'b10 instead: stored word = 16'h2211 and collision = 0.
- Cross-port read-first: addr 7 holds 16'hA5A5; port 2 writes 16'hBEEF to addr 7 while port 1 reads addr 7 -> dout1 = 16'hA5A5. Next port 1 read -> 16'hBEEF.
- Latency 2 and reset mid-clear:
  - With READ_LATENCY = 2, a read issued in cycle N -> valid1 = 1 in cycle N+2.
  - Reassert reset at clear address 8 -> busy stays 1 for 16 further cycles after release.
  - An en1 write while busy = 1 is dropped: that address reads 16'hA5A5.
- Parity (TWOPORTBRAM_PARITY_EN defined):
  - Force a flip of stored bit 0 at addr 2, then read -> perr1 = 1 together with valid1.
  - A clean read -> perr1 = 0.
  - With the macro undefined -> perr1 = 0 always.
